dec_2to4_strobe: RTL and testbench

//   Registered, active-low-enable binary-to-one-hot decoder: the inverse of the 4-to-2 encoder family.

---
 rtl/dec_2to4_strobe_pkg.sv | 14 +
 rtl/dec_2to4_strobe_if.sv | 31 +++
 rtl/dec_2to4_strobe_onehot.sv | 16 +
 rtl/dec_2to4_strobe.sv | 108 ++++++++++
 tb/tb_dec_2to4_strobe.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/dec_2to4_strobe_pkg.sv
// Shared definitions for the binary/one-hot encoder-decoder family:
// FSM state encoding and the one-hot width derivation.
package dec_2to4_strobe_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } dec_state_e;

   function automatic int out_w(input int in_w);
      return 1 << in_w;
   endfunction

endpackage

// File: rtl/dec_2to4_strobe_if.sv
// Code handshake and one-hot result bundle between a command source and the decoder.
// Handshake: a code transfers on a rising edge where code_valid & code_ready are both high;
// code_ready is combinational, and a request seen while code_ready=0 is dropped, not queued.
interface dec_2to4_strobe_if
   import dec_2to4_strobe_pkg::*;
#(
   parameter int IN_W  = 2,
   parameter int CNT_W = 8
);
   localparam int OUT_W = out_w(IN_W);

   logic             en_n;
   logic             code_valid;
   logic [IN_W-1:0]  code;
   logic             code_ready;
   logic [OUT_W-1:0] y;
   logic             y_valid;
   logic             done;
   logic [CNT_W-1:0] acc_cnt;

   modport master (
      output en_n, code_valid, code,
      input  code_ready, y, y_valid, done, acc_cnt
   );

   modport slave (
      input  en_n, code_valid, code,
      output code_ready, y, y_valid, done, acc_cnt
   );

endinterface

// File: rtl/dec_2to4_strobe_onehot.sv
// Combinational binary to one-hot decode with no enable; gating happens in the caller.
module dec_onehot
   import dec_2to4_strobe_pkg::*;
#(
   parameter int IN_W = 2
) (
   input  logic [IN_W-1:0]        code,
   output logic [out_w(IN_W)-1:0] onehot
);

   always_comb begin
      onehot       = '0;
      onehot[code] = 1'b1;
   end

endmodule

// File: rtl/dec_2to4_strobe.sv
// Registered active-low-enable decoder: drives the one-hot line for an accepted code
// for HOLD_CYC clocks, pulses done when the hold ends, and counts accepted codes.
module dec_2to4_strobe
   import dec_2to4_strobe_pkg::*;
#(
   parameter int IN_W     = 2,
   parameter int HOLD_CYC = 4,
   parameter int CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   dec_2to4_strobe_if.slave   bus,
   output dec_state_e         state_dbg
);

   localparam int OUT_W  = out_w(IN_W);
   localparam int HCNT_W = 8;
   localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   dec_state_e        state_q;
   dec_state_e        state_d;
   logic [HCNT_W-1:0] hcnt_q;
   logic [OUT_W-1:0]  y_q;
   logic              y_valid_q;
   logic              done_q;
   logic [CNT_W-1:0]  acc_cnt_q;

   logic              hold_last;
   logic              code_ready;
   logic              accept;
   logic [OUT_W-1:0]  decoded;

   dec_onehot #(
      .IN_W (IN_W)
   ) u_onehot (
      .code   (bus.code),
      .onehot (decoded)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; disable wins over any pending transfer
   always_comb begin
      state_d = state_q;
      if (bus.en_n) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (accept) state_d = ST_HOLD;
            ST_HOLD: if (hold_last) state_d = accept ? ST_HOLD : ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output/handshake logic: ready in IDLE and on the final hold clock for gapless reload
   always_comb begin
      hold_last  = (state_q == ST_HOLD) && (hcnt_q == HOLD_LAST);
      code_ready = !bus.en_n && ((state_q == ST_IDLE) || hold_last);
      accept     = bus.code_valid && code_ready;
   end

   // Datapath registers; acc_cnt survives a disable but not a reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hcnt_q    <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         done_q    <= 1'b0;
         acc_cnt_q <= '0;
      end else if (bus.en_n) begin
         hcnt_q    <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= hold_last;
         if (accept) begin
            y_q       <= decoded;
            y_valid_q <= 1'b1;
            hcnt_q    <= '0;
            if (acc_cnt_q != CNT_MAX) acc_cnt_q <= acc_cnt_q + 1'b1;
         end else if (hold_last) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            hcnt_q    <= '0;
         end else if (state_q == ST_HOLD) begin
            hcnt_q <= hcnt_q + 1'b1;
         end
      end
   end

   assign bus.code_ready = code_ready;
   assign bus.y          = y_q;
   assign bus.y_valid    = y_valid_q;
   assign bus.done       = done_q;
   assign bus.acc_cnt    = acc_cnt_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_dec_2to4_strobe.sv
// Bench for dec_2to4_strobe: a default instance (HOLD_CYC=4, CNT_W=8) and an edge instance
// (HOLD_CYC=1, CNT_W=2), both compared every clock against a remaining-hold-count model.
module tb_dec_2to4_strobe;
   import dec_2to4_strobe_pkg::*;

   typedef struct {
      logic [3:0] y;
      logic       yv;
      logic       done;
      int         cnt;
      int         rem;
   } mdl_t;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   int   done_cnt0;

   logic [14:0] exp_q[$];
   logic [8:0]  exp_q1[$];
   mdl_t        m0;
   mdl_t        m1;
   dec_state_e  st0;
   dec_state_e  st1;

   dec_2to4_strobe_if #(.IN_W(2), .CNT_W(8)) b0 ();
   dec_2to4_strobe_if #(.IN_W(2), .CNT_W(2)) b1 ();

   dec_2to4_strobe #(.IN_W(2), .HOLD_CYC(4), .CNT_W(8)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (b0),
      .state_dbg (st0)
   );

   dec_2to4_strobe #(.IN_W(2), .HOLD_CYC(1), .CNT_W(2)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (b1),
      .state_dbg (st1)
   );

   // Clock/reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic mdl_t step(input mdl_t m, input logic rst_i, input logic en_n_i,
                                 input logic v_i, input logic [1:0] c_i,
                                 input int hold, input int cmax);
      mdl_t n;
      logic acc;
      n = m;
      if (!rst_i) begin
         n.y = '0; n.yv = 1'b0; n.done = 1'b0; n.cnt = 0; n.rem = 0;
      end else if (en_n_i) begin
         n.y = '0; n.yv = 1'b0; n.done = 1'b0; n.rem = 0;
      end else begin
         acc    = v_i && (m.rem <= 1);
         n.done = (m.rem == 1);
         if (acc) begin
            n.y   = 4'b0001 << c_i;
            n.yv  = 1'b1;
            n.rem = hold;
            if (m.cnt < cmax) n.cnt = m.cnt + 1;
         end else if (m.rem > 0) begin
            n.rem = m.rem - 1;
            if (n.rem == 0) begin
               n.y  = '0;
               n.yv = 1'b0;
            end
         end
      end
      return n;
   endfunction

   // Scoreboard: model steps on the edge, DUT outputs compared 1 time unit later
   always @(posedge clk) begin
      m0 = step(m0, rst_n, b0.en_n, b0.code_valid, b0.code, 4, 255);
      m1 = step(m1, rst_n, b1.en_n, b1.code_valid, b1.code, 1, 3);
      exp_q.push_back({m0.y, m0.yv, m0.done, 8'(m0.cnt), m0.rem > 0});
      exp_q1.push_back({m1.y, m1.yv, m1.done, 2'(m1.cnt), m1.rem > 0});
      #1;
      check("out0", {b0.y, b0.y_valid, b0.done, b0.acc_cnt, st0 == ST_HOLD}, exp_q.pop_front());
      check("out1", {b1.y, b1.y_valid, b1.done, b1.acc_cnt, st1 == ST_HOLD}, exp_q1.pop_front());
      check("onehot0", 32'($countones(b0.y) <= 1), 1);
      if (b0.done) done_cnt0++;
   end

   always @(negedge clk) begin
      #2;
      check("ready0", b0.code_ready, !b0.en_n && (m0.rem <= 1));
      check("ready1", b1.code_ready, !b1.en_n && (m1.rem <= 1));
   end

   // Driver tasks: called at a falling edge, return at the next falling edge
   task automatic step0(input logic en_i, input logic v_i, input logic [1:0] c_i);
      b0.en_n = en_i; b0.code_valid = v_i; b0.code = c_i;
      @(negedge clk);
   endtask

   task automatic offer0(input logic [1:0] c_i);
      int   n;
      logic rdy;
      n = 0;
      b0.en_n = 1'b0; b0.code_valid = 1'b1; b0.code = c_i;
      do begin
         #1 rdy = b0.code_ready;
         @(negedge clk);
         n++;
      end while (!rdy && n < 20);
      check("offer_accept", rdy, 1);
      b0.code_valid = 1'b0;
   endtask

   task automatic idle0(input int n);
      for (int i = 0; i < n; i++) step0(1'b0, 1'b0, 2'b00);
   endtask

   initial begin
      int d_before;
      errors = 0; checks = 0; done_cnt0 = 0;
      m0 = '{y: '0, yv: 1'b0, done: 1'b0, cnt: 0, rem: 0};
      m1 = m0;
      rst_n = 1'b0;
      b0.en_n = 1'b0; b0.code_valid = 1'b1; b0.code = 2'b01;
      b1.en_n = 1'b0; b1.code_valid = 1'b0; b1.code = 2'b00;
      // Reset with a request pending
      repeat (2) @(negedge clk);
      check("rst_cnt", b0.acc_cnt, 0);
      rst_n = 1'b1;

      // Basic decode
      d_before = done_cnt0;
      step0(1'b0, 1'b1, 2'b10);
      idle0(6);
      check("t2_cnt", b0.acc_cnt, 1);
      check("t2_done", done_cnt0 - d_before, 1);

      // Sweep, back-to-back
      d_before = done_cnt0;
      for (int i = 0; i < 4; i++) offer0(2'(i));
      idle0(6);
      check("t3_cnt", b0.acc_cnt, 5);
      check("t3_done", done_cnt0 - d_before, 4);

      // Disable mid-hold
      d_before = done_cnt0;
      offer0(2'b01);
      step0(1'b0, 1'b0, 2'b00);
      step0(1'b1, 1'b0, 2'b00);
      step0(1'b1, 1'b1, 2'b11);
      idle0(6);
      check("t4_cnt", b0.acc_cnt, 6);
      check("t4_done", done_cnt0 - d_before, 0);

      // Request during hold is held off until the last hold clock
      offer0(2'b01);
      offer0(2'b11);
      idle0(6);
      check("t5_cnt", b0.acc_cnt, 8);

      // Reset mid-hold
      offer0(2'b10);
      step0(1'b0, 1'b0, 2'b00);
      rst_n = 1'b0;
      step0(1'b0, 1'b1, 2'b01);
      rst_n = 1'b1;
      idle0(6);
      check("rst_mid_cnt", b0.acc_cnt, 0);

      // Random traffic
      for (int i = 0; i < 300; i++)
         step0(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      idle0(6);

      // HOLD_CYC=1 continuous valid, CNT_W=2 saturation
      for (int i = 0; i < 6; i++) begin
         b1.code_valid = 1'b1;
         b1.code = 2'($urandom_range(0, 3));
         @(negedge clk);
      end
      b1.code_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_sat", b1.acc_cnt, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
